lookahead_4bit: RTL and testbench
=================================

Name: lookahead_4bit

Overview:
- 4-bit carry-lookahead adder with registered outputs.
- Computes per-bit generate/propagate, all internal carries in parallel, the sum, the carry-out and the group propagate/generate (PG/GG) terms.
- PG/GG let a second-level lookahead unit cascade several instances into wider adders.
- Sits in the datapath as a one-cycle-latency arithmetic stage.

Parameters:
- none. Width is fixed at 4 bits.

Ports:
- clk    input   1  rising-edge clock
- rst_n  input   1  asynchronous active-low reset
- A      input   4  operand A, unsigned
- B      input   4  operand B, unsigned
- c_in   input   1  carry-in
- S      output  4  registered sum bits
- c_out  output  1  registered carry-out
- PG     output  1  registered group propagate
- GG     output  1  registered group generate

Behaviour:
- Reset:
  - rst_n low asynchronously forces S=0000, c_out=0, PG=0, GG=0, independent of clk.
  - Outputs hold these values while rst_n is low.
  - First capture occurs at the first rising clk edge after rst_n deasserts.
- Per-bit terms, i=0..3:
  - g[i] = A[i] & B[i]
  - p[i] = A[i] ^ B[i] (XOR propagate, reused for the sum)
- Carries, all computed in parallel with no ripple chain:
  - c0 = c_in
  - c1 = g0 | p0·c0
  - c2 = g1 | p1·g0 | p1·p0·c0
  - c3 = g2 | p2·g1 | p2·p1·g0 | p2·p1·p0·c0
  - c4 = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0 | p3·p2·p1·p0·c0
- Sum: S[i] = p[i] ^ c[i].
- Group terms:
  - PG = p3·p2·p1·p0
  - GG = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0
  - GG and PG are independent of c_in.
- Carry-out: c_out = c4 = GG | (PG & c_in).
  - Must equal bit 4 of A + B + c_in.
- Invariant: {c_out, S} == A + B + c_in (5-bit, unsigned); wrap-around is carried entirely by c_out.
- PG and GG are never both 1. An XOR propagate with p[i]=1 implies g[i]=0.
- Latency:
  - Inputs sampled at every rising clk edge; all four outputs update together at that edge.
  - Latency is exactly 1 cycle and throughput is 1 result per cycle.
  - No enable or handshake: every edge captures new operands.
- Input changes between edges have no effect on outputs until the next edge; outputs never glitch between edges.
- Reset asserted mid-operation discards any in-flight result immediately. The first post-reset edge outputs the result of the operands present at that edge.
- Combinational core is pure logic: no latches, no dependence on output registers.

Test Plan:
- Reset: hold rst_n=0 with A=1111, B=1111, c_in=1 and toggle clk -> S=0000, c_out=0, PG=0, GG=0. Assert rst_n asynchronously mid-cycle -> outputs clear without waiting for a clk edge.
- Basic adds, each checked one edge after applying operands:
  - A=0001, B=0000, c_in=0 -> S=0001, c_out=0, PG=0, GG=0
  - A=0100, B=0011, c_in=0 -> S=0111, c_out=0, PG=0, GG=0
- Generate-driven carry-out:
  - A=1101, B=1010, c_in=1 -> S=1000, c_out=1, PG=0, GG=1
  - A=1110, B=1001, c_in=0 -> S=0111, c_out=1, GG=1
  - A=1111, B=1010, c_in=0 -> S=1001, c_out=1, GG=1
- Maximum input: A=1111, B=1111, c_in=1 -> S=1111, c_out=1, PG=0, GG=1.
- Full propagate chain:
  - A=1010, B=0101, c_in=1 -> S=0000, c_out=1, PG=1, GG=0
  - same operands with c_in=0 -> S=1111, c_out=0, PG=1, GG=0
- Exhaustive and timing: all 512 combinations of {A,B,c_in} applied back-to-back, one per cycle. Check {c_out,S}==A+B+c_in, the PG/GG formulas, and that each result appears exactly one cycle after its operands.

Source files
------------

// File: rtl/lookahead_4bit.sv
// lookahead_4bit: 4-bit carry-lookahead adder with one register stage.
// Produces the sum, the carry-out and the group propagate/generate terms
// that a second-level lookahead unit uses to cascade several of these.
module lookahead_4bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       c_in,
  output logic [3:0] S,
  output logic       c_out,
  output logic       PG,
  output logic       GG
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;
  logic [3:0] s_d;
  logic       pg_d;
  logic       gg_d;

  // Lookahead core: every carry is a flat sum-of-products, with no ripple chain.
  // p is the XOR propagate, so it is also reused to form the sum.
  always_comb begin
    g    = A & B;
    p    = A ^ B;
    c[0] = c_in;
    c[1] = g[0] | (p[0] & c_in);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c_in);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c_in);
    pg_d = &p;
    gg_d = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]);
    s_d  = p ^ c[3:0];
  end

  // Output stage: all four results are captured together on every rising edge.
  // An asynchronous reset clears them and drops any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S     <= '0;
      c_out <= 1'b0;
      PG    <= 1'b0;
      GG    <= 1'b0;
    end else begin
      S     <= s_d;
      c_out <= c[4];
      PG    <= pg_d;
      GG    <= gg_d;
    end
  end

endmodule

// File: tb/tb_lookahead_4bit.sv
// tb_lookahead_4bit: scoreboard bench for the registered 4-bit lookahead adder.
// Operands are driven just after a rising edge; the expected result is queued
// with the cycle in which it must appear, and a monitor compares on falling edges.
module tb_lookahead_4bit;

  logic       clk;
  logic       rst_n;
  logic [3:0] A;
  logic [3:0] B;
  logic       c_in;
  logic [3:0] S;
  logic       c_out;
  logic       PG;
  logic       GG;

  typedef struct {
    logic [6:0]  exp;
    int unsigned due;
    logic [3:0]  a;
    logic [3:0]  b;
    logic        c;
  } item_t;

  item_t       sbq[$];
  int unsigned cyc;
  int unsigned n_checks;
  int unsigned n_fail;

  lookahead_4bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .c_in  (c_in),
    .S     (S),
    .c_out (c_out),
    .PG    (PG),
    .GG    (GG)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Reference: plain arithmetic. GG is "A+B overflows on its own",
  // PG is "A+B is all ones so any carry-in passes straight through".
  function automatic logic [6:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic c);
    logic [4:0] full;
    logic       pg;
    logic       gg;
    full = 5'(a) + 5'(b) + 5'(c);
    gg   = (5'(a) + 5'(b)) > 5'd15;
    pg   = (5'(a) + 5'(b)) == 5'd15;
    return {full, pg, gg};
  endfunction

  function automatic logic [6:0] actual();
    return {c_out, S, PG, GG};
  endfunction

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got {c_out,S,PG,GG}=%b_%b_%b_%b expected %b_%b_%b_%b",
               name, got[6], got[5:2], got[1], got[0],
               exp[6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  // Called at posedge+1: operands are captured at the next rising edge.
  task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic c);
    item_t it;
    A       = a;
    B       = b;
    c_in    = c;
    it.exp  = model(a, b, c);
    it.due  = cyc + 1;
    it.a    = a;
    it.b    = b;
    it.c    = c;
    sbq.push_back(it);
    @(posedge clk);
    #1;
  endtask

  // Monitor: the result due in this cycle must be on the outputs mid-cycle,
  // after the inputs have already moved on to the next operands.
  always @(negedge clk) begin
    if (sbq.size() > 0 && sbq[0].due <= cyc) begin
      item_t it;
      string nm;
      it = sbq.pop_front();
      $sformat(nm, "add A=%b B=%b cin=%b", it.a, it.b, it.c);
      if (it.due != cyc) begin
        n_checks = n_checks + 1;
        n_fail   = n_fail + 1;
        $display("FAIL %s: result checked in cycle %0d, required cycle %0d",
                 nm, cyc, it.due);
      end else begin
        check(nm, actual(), it.exp);
      end
    end
  end

  initial begin
    int unsigned waited;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    A        = 4'hF;
    B        = 4'hF;
    c_in     = 1'b1;

    // Reset held with the largest operands while the clock runs.
    repeat (3) begin
      @(negedge clk);
      check("reset_hold", actual(), 7'b0);
    end

    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed cases.
    apply(4'b0001, 4'b0000, 1'b0);
    apply(4'b0100, 4'b0011, 1'b0);
    apply(4'b1101, 4'b1010, 1'b1);
    apply(4'b1110, 4'b1001, 1'b0);
    apply(4'b1111, 4'b1010, 1'b0);
    apply(4'b1111, 4'b1111, 1'b1);
    apply(4'b1010, 4'b0101, 1'b1);
    apply(4'b1010, 4'b0101, 1'b0);

    // Exhaustive sweep back-to-back, one operand set per cycle.
    for (int unsigned i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      apply(v[8:5], v[4:1], v[0]);
    end

    // Random operands.
    repeat (64) begin
      apply(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));
    end

    // Leave a nonzero result on the outputs, then reset between edges.
    apply(4'hF, 4'hF, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    sbq.delete();
    #1;
    check("async_reset_midcycle", actual(), 7'b0);
    A    = 4'hF;
    B    = 4'hF;
    c_in = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("reset_hold_again", actual(), 7'b0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply(4'b1001, 4'b0111, 1'b1);
    apply(4'b0110, 4'b0110, 1'b0);

    // Drain the scoreboard with a bounded wait.
    waited = 0;
    while (sbq.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited = waited + 1;
    end
    if (sbq.size() > 0) begin
      n_checks = n_checks + 1;
      n_fail   = n_fail + 1;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sbq.size());
    end
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
